// File: rtl/fir_param.sv
// Parametrised direct-form FIR filter with run-time coefficient loading.
// Two-stage pipeline (products, then sum/scale/saturate), fixed 2-cycle latency.
module fir_param #(
    parameter int NT  = 11,
    parameter int DW  = 8,
    parameter int AW  = 6,
    parameter int SAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic signed [DW-1:0] DIN,
    input  logic                 VIN,
    input  logic                 COEF_WE,
    input  logic [AW-1:0]        COEF_ADDR,
    input  logic signed [DW-1:0] COEF_DATA,
    output logic signed [DW-1:0] DOUT,
    output logic                 VOUT,
    output logic                 OVF
);

    localparam int PW    = 2 * DW;
    localparam int ACC_W = PW + $clog2(NT);
    localparam int SH_W  = ACC_W - DW + 1;

    // Clamp to the nearest bound when saturating; otherwise keep the low DW bits.
    function automatic logic signed [DW-1:0] fit_out(input logic signed [SH_W-1:0] v,
                                                     input logic ovf);
        logic signed [DW-1:0] r;
        if (ovf && (SAT != 0)) begin
            r = v[SH_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    logic signed [DW-1:0]    x_r [NT];
    logic signed [DW-1:0]    h_r [NT];
    logic signed [PW-1:0]    p_r [NT];
    logic                    v0_r;
    logic                    v1_r;
    logic signed [ACC_W-1:0] acc_s;
    logic signed [SH_W-1:0]  sh_s;
    logic                    ovf_s;
    logic signed [DW-1:0]    res_s;
    logic                    acc_unused_s;

    // Delay line, coefficient bank and accept flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NT; i++) begin
                x_r[i] <= {DW{1'b0}};
                h_r[i] <= {DW{1'b0}};
            end
            v0_r <= 1'b0;
        end else begin
            v0_r <= VIN;
            if (VIN) begin
                x_r[0] <= DIN;
                for (int i = 1; i < NT; i++) begin
                    x_r[i] <= x_r[i-1];
                end
            end
            // Out-of-range addresses match no tap and are dropped.
            if (COEF_WE) begin
                for (int i = 0; i < NT; i++) begin
                    if (COEF_ADDR == AW'(i)) begin
                        h_r[i] <= COEF_DATA;
                    end
                end
            end
        end
    end

    // Stage 1: full-precision tap products.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NT; i++) begin
                p_r[i] <= {PW{1'b0}};
            end
            v1_r <= 1'b0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                p_r[i] <= PW'(x_r[i]) * PW'(h_r[i]);
            end
            v1_r <= v0_r;
        end
    end

    // Sum products, drop DW-1 fraction bits and detect out-of-range results.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int i = 0; i < NT; i++) begin
            acc_s = acc_s + ACC_W'(p_r[i]);
        end
        sh_s         = acc_s[ACC_W-1:DW-1];
        acc_unused_s = ^acc_s[DW-2:0];
        ovf_s        = (sh_s[SH_W-1:DW-1] != {(SH_W-DW+1){sh_s[DW-1]}});
        res_s        = fit_out(sh_s, ovf_s);
    end

    // Stage 2: registered outputs; DOUT holds between valid pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= {DW{1'b0}};
            VOUT <= 1'b0;
            OVF  <= 1'b0;
        end else begin
            VOUT <= v1_r;
            if (v1_r) begin
                DOUT <= res_s;
                OVF  <= ovf_s;
            end else begin
                OVF  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: a saturating and a wrapping instance share stimulus.
module tb_fir_param;

    logic              clk = 1'b0;
    logic              rst;
    logic              vin;
    logic              coef_we;
    logic signed [7:0] din;
    logic signed [7:0] coef_data;
    logic [5:0]        coef_addr;
    logic signed [7:0] dout_a, dout_b;
    logic              vout_a, vout_b, ovf_a, ovf_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic signed [7:0] qa_d[$];
    logic signed [7:0] qb_d[$];
    logic              qa_o[$];
    logic              qb_o[$];
    int                qa_t[$];
    int                exp_t[$];

    fir_param #(.NT(11), .DW(8), .AW(6), .SAT(1)) u_sat (
        .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .COEF_WE(coef_we),
        .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .DOUT(dout_a), .VOUT(vout_a), .OVF(ovf_a)
    );

    fir_param #(.NT(11), .DW(8), .AW(6), .SAT(0)) u_wrap (
        .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .COEF_WE(coef_we),
        .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .DOUT(dout_b), .VOUT(vout_b), .OVF(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture on the falling edge.
    always @(negedge clk) begin
        if (vout_a === 1'b1) begin
            qa_d.push_back(dout_a);
            qa_o.push_back(ovf_a);
            qa_t.push_back(cyc);
        end
        if (vout_b === 1'b1) begin
            qb_d.push_back(dout_b);
            qb_o.push_back(ovf_b);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] d);
        vin = 1'b1;
        din = d;
        tick();
        exp_t.push_back(cyc);
        vin = 1'b0;
        din = 8'sd0;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = a[5:0];
        coef_data = d[7:0];
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic clear_q();
        qa_d.delete(); qb_d.delete(); qa_o.delete(); qb_o.delete();
        qa_t.delete(); exp_t.delete();
    endtask

    function automatic int exp_imp(input int j);
        return (j < 11) ? -(j + 1) : 0;
    endfunction

    task automatic check_impulse(input string tag);
        check({tag, "_cnt_a"}, qa_d.size(), 12);
        check({tag, "_cnt_b"}, qb_d.size(), 12);
        for (int j = 0; j < 12 && j < qa_d.size() && j < qb_d.size(); j++) begin
            check({tag, "_dout_a"}, qa_d[j], exp_imp(j));
            check({tag, "_dout_b"}, qb_d[j], exp_imp(j));
            check({tag, "_ovf"}, qa_o[j], 0);
            check({tag, "_time"}, qa_t[j], exp_t[j] + 2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vin = 1'b1; din = 8'sd55;
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 8'sd77;
        repeat (3) tick();
        check("rst_dout_a", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_vout", vout_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst = 1'b0; vin = 1'b0; coef_we = 1'b0; din = 8'sd0;
        idle(1);

        // Impulse with coefficients never written: all zeros.
        clear_q();
        send(8'sh80);
        repeat (11) send(8'sd0);
        idle(3);
        check("zc_cnt", qa_d.size(), 12);
        for (int j = 0; j < 12 && j < qa_d.size(); j++) check("zc_dout", qa_d[j], 0);

        // Impulse response with h[i] = i+1, back-to-back input.
        for (int i = 0; i < 11; i++) wr(i, i + 1);
        clear_q();
        send(8'sh80);
        repeat (11) send(8'sd0);
        idle(3);
        check_impulse("imp");

        // Same impulse with a 1,0,0 valid pattern.
        clear_q();
        for (int j = 0; j < 12; j++) begin
            vin = 1'b1;
            din = (j == 0) ? 8'sh80 : 8'sd0;
            tick();
            exp_t.push_back(cyc);
            if (j > 0) begin
                check("gap_hold", dout_a, exp_imp(j - 1));
                check("gap_vout", vout_a, 0);
            end
            vin = 1'b0;
            din = 8'sd0;
            tick();
            tick();
        end
        idle(2);
        check_impulse("gap");

        // Saturation versus wrap with all h = -128.
        for (int i = 0; i < 11; i++) wr(i, -128);
        clear_q();
        repeat (11) send(8'sh80);
        idle(3);
        check("sat_cnt_a", qa_d.size(), 11);
        check("sat_cnt_b", qb_d.size(), 11);
        if (qa_d.size() == 11 && qb_d.size() == 11) begin
            check("sat_first_a", qa_d[0], 127);
            check("sat_last_a", qa_d[10], 127);
            check("sat_last_ovf_a", qa_o[10], 1);
            check("wrap_last_b", qb_d[10], -128);
            check("wrap_last_ovf_b", qb_o[10], 1);
            check("wrap_second_b", qb_d[1], 0);
            check("wrap_second_ovf_b", qb_o[1], 1);
        end
        check("ovf_idle_a", ovf_a, 0);
        check("ovf_idle_b", ovf_b, 0);
        check("hold_idle_a", dout_a, 127);

        // Coefficient written in the same cycle as the sample.
        rst = 1'b1; tick(); rst = 1'b0;
        clear_q();
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 8'sd64;
        vin = 1'b1; din = 8'sd64;
        tick();
        exp_t.push_back(cyc);
        coef_we = 1'b0; vin = 1'b0; din = 8'sd0;
        idle(3);
        check("cw_cnt", qa_d.size(), 1);
        if (qa_d.size() == 1) begin
            check("cw_dout", qa_d[0], 32);
            check("cw_time", qa_t[0], exp_t[0] + 2);
        end

        // Writes beyond the last tap must not land anywhere.
        wr(11, 127);
        wr(12, 127);
        wr(63, 127);
        clear_q();
        repeat (11) send(8'sd64);
        idle(3);
        check("oob_cnt", qa_d.size(), 11);
        if (qa_d.size() == 11) begin
            check("oob_first", qa_d[0], 32);
            check("oob_full", qa_d[10], 32);
        end

        // Reset one cycle after an accepted sample.
        clear_q();
        send(8'sd64);
        rst = 1'b1; tick(); rst = 1'b0;
        idle(4);
        check("mid_rst_cnt", qa_d.size(), 0);
        clear_q();
        wr(10, 64);
        repeat (3) send(8'sd100);
        idle(3);
        check("post_rst_cnt", qa_d.size(), 3);
        for (int j = 0; j < 3 && j < qa_d.size(); j++) check("post_rst_dout", qa_d[j], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_param.md
Name: fir_param

Overview:
- Parametrised direct-form FIR filter; generalised successor of the fixed 8-bit, 11-tap myfir.
- Tap count, data width and output saturation are set by parameters.
- Coefficients are loaded at run time through a write port instead of N+1 static input buses.
- Placed between data_maker-style sources and data_sink-style sinks; uses the same VIN/VOUT valid protocol with gap (pause) tolerance.

Parameters:
- NT, 11, number of taps (coefficients); legal range 2..64.
- DW, 8, data and coefficient width; signed two's complement Q1.(DW-1).
- AW, 6, coefficient address width; 2^AW >= NT is required.
- SAT, 1, 1 = saturate DOUT on overflow; 0 = wrap (two's-complement truncation).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  DW  input sample, signed.
- VIN  in  1  DIN valid; sample accepted on any edge with VIN=1.
- COEF_WE  in  1  coefficient write enable.
- COEF_ADDR  in  AW  tap index to write (0 = h0, applied to newest sample).
- COEF_DATA  in  DW  coefficient value, signed.
- DOUT  out  DW  filtered output, signed Q1.(DW-1).
- VOUT  out  1  DOUT valid, one-cycle pulse per accepted sample.
- OVF  out  1  high together with VOUT when that output saturated or wrapped.

Behaviour:
- Reset (RST=1 at an edge) clears, at that edge:
  - delay line x[0..NT-1];
  - all coefficients;
  - product pipeline registers;
  - DOUT, VOUT and OVF (all 0).
  - Reset overrides VIN and COEF_WE in the same cycle.
  - Reset mid-stream discards every in-flight sample; no VOUT follows it.
- Coefficient write: COEF_WE=1 at edge k writes COEF_DATA into h[COEF_ADDR].
  - Addresses >= NT are ignored.
  - Writes are legal at any time.
- Delay line:
  - VIN=1 at edge k: x[0] <= DIN, x[i] <= x[i-1].
  - VIN=0: the line holds. Gaps of any length are allowed; no bubbles enter the line.
- Pipeline, for a sample accepted at edge k:
  - Stage 1 (edge k+1): p[i] <= x[i]*h[i], full 2*DW-bit signed products, using x and h values after edge k. A coefficient write accepted at edge k therefore applies to the sample accepted at edge k.
  - Stage 2 (edge k+2): acc = sum of p[i] in 2*DW+clog2(NT) bits; DOUT <= acc[2*DW-2 : DW-1], i.e. arithmetic shift right by DW-1.
  - VOUT=1 for exactly the cycle after edge k+2. Latency is fixed at 2 cycles.
  - Back-to-back VIN gives one output per cycle.
- Overflow handling, when the shifted acc is outside [-2^(DW-1), 2^(DW-1)-1]:
  - SAT=1: DOUT is clamped to the nearest bound.
  - SAT=0: DOUT keeps the low DW bits.
  - In both cases OVF=1 with that VOUT.
- Hold rules:
  - DOUT holds its last value while VOUT=0.
  - OVF=0 whenever VOUT=0.
- Warm-up: the first NT-1 outputs after reset use zeros in the unfilled delay-line positions. There is no suppression of these outputs.

Test Plan:
- Reset values: RST high 3 cycles with VIN=1 and COEF_WE=1 → DOUT=0, VOUT=0, OVF=0; a subsequent impulse with no writes yields all-zero outputs.
- Impulse (NT=11, DW=8): write h[i]=i+1; DIN=-128 once, then 11 zeros, VIN=1 throughout → DOUT sequence -1,-2,…,-11, then 0; first VOUT 2 cycles after the impulse edge.
- Pause tolerance: same impulse with VIN toggling 1,0,0,1,… → identical DOUT value sequence, one VOUT per VIN edge at +2 cycles, DOUT stable across gaps.
- Saturation: all h=-128, DIN=-128 for 11 consecutive samples:
  - SAT=1 → 11th output DOUT=127, OVF=1;
  - SAT=0 → 11th output DOUT=-128 (1408 mod 256), OVF=1.
- Coefficient write timing:
  - write h0=64 in the same cycle as VIN with DIN=64 (previous h0=0) → that output DOUT=32;
  - a write to COEF_ADDR=12 changes no output.
- Reset mid-stream: RST asserted 1 cycle after a VIN edge → no VOUT for that sample; all later outputs computed from a cleared line and cleared coefficients.
